// File: rtl/temp_pkg.sv
// Shared types and sizes for the temperature sweep generator.
package temp_pkg;

    localparam int TEMP_W    = 8;
    localparam int HITS_W    = 9;
    localparam int DWELL_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps on terminal count.
// tc_o flags the last cycle of each dwell period; clr_i forces the count to 0.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tc_o = en_i && (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/temp_sweep_gen.sv
// Sweeps a temperature code lo..hi in steps, holding each for DWELL cycles,
// and records how many codes tripped the indicator plus the first/last tripping code.
module temp_sweep_gen
    import temp_pkg::*;
#(
    parameter int DWELL = DWELL_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [TEMP_W-1:0] lo_i,
    input  logic [TEMP_W-1:0] hi_i,
    input  logic [3:0]        step_i,
    input  logic              ind_i,
    output logic [TEMP_W-1:0] temp_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [HITS_W-1:0] hits_o,
    output logic              any_hit_o,
    output logic [TEMP_W-1:0] first_hit_o,
    output logic [TEMP_W-1:0] last_hit_o
);

    state_t            state_q, state_d;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic [TEMP_W-1:0] hi_q, hi_d;
    logic [3:0]        step_q, step_d;
    logic [HITS_W-1:0] hits_q, hits_d;
    logic              any_hit_q, any_hit_d;
    logic [TEMP_W-1:0] first_hit_q, first_hit_d;
    logic [TEMP_W-1:0] last_hit_q, last_hit_d;

    logic              sweeping;
    logic              dwell_end;
    logic [TEMP_W:0]   next_sum;

    assign sweeping = (state_q == SWEEP);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (!sweeping),
        .en_i  (sweeping),
        .tc_o  (dwell_end)
    );

    // Nine-bit sum so a step past 255 reads as "beyond hi" instead of wrapping.
    assign next_sum = {1'b0, temp_q} + {5'b0, step_q};

    always_comb begin
        state_d     = state_q;
        temp_d      = temp_q;
        hi_d        = hi_q;
        step_d      = step_q;
        hits_d      = hits_q;
        any_hit_d   = any_hit_q;
        first_hit_d = first_hit_q;
        last_hit_d  = last_hit_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    hi_d        = hi_i;
                    step_d      = (step_i == 4'd0) ? 4'd1 : step_i;
                    hits_d      = '0;
                    any_hit_d   = 1'b0;
                    first_hit_d = '0;
                    last_hit_d  = '0;
                    if (lo_i > hi_i) begin
                        state_d = DONE;
                    end else begin
                        temp_d  = lo_i;
                        state_d = SWEEP;
                    end
                end
            end
            SWEEP: begin
                if (dwell_end) begin
                    if (ind_i) begin
                        hits_d     = hits_q + 9'd1;
                        any_hit_d  = 1'b1;
                        last_hit_d = temp_q;
                        if (!any_hit_q) begin
                            first_hit_d = temp_q;
                        end
                    end
                    if (next_sum > {1'b0, hi_q}) begin
                        state_d = DONE;
                    end else begin
                        temp_d = next_sum[TEMP_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            temp_q      <= '0;
            hi_q        <= '0;
            step_q      <= 4'd1;
            hits_q      <= '0;
            any_hit_q   <= 1'b0;
            first_hit_q <= '0;
            last_hit_q  <= '0;
        end else begin
            state_q     <= state_d;
            temp_q      <= temp_d;
            hi_q        <= hi_d;
            step_q      <= step_d;
            hits_q      <= hits_d;
            any_hit_q   <= any_hit_d;
            first_hit_q <= first_hit_d;
            last_hit_q  <= last_hit_d;
        end
    end

    assign temp_o      = temp_q;
    assign busy_o      = sweeping;
    assign done_o      = (state_q == DONE);
    assign hits_o      = hits_q;
    assign any_hit_o   = any_hit_q;
    assign first_hit_o = first_hit_q;
    assign last_hit_o  = last_hit_q;

endmodule

// File: tb/tb_temp_sweep_gen.sv
// Self-checking bench for temp_sweep_gen with a behavioural indicator and sweep model.
module tb_temp_sweep_gen;

    localparam int DW    = 4;
    localparam int BOUND = 3000;

    logic       clk_i;
    logic       rst_i;
    logic       start_i;
    logic [7:0] lo_i;
    logic [7:0] hi_i;
    logic [3:0] step_i;
    logic       ind_i;
    logic [7:0] temp_o;
    logic       busy_o;
    logic       done_o;
    logic [8:0] hits_o;
    logic       any_hit_o;
    logic [7:0] first_hit_o;
    logic [7:0] last_hit_o;

    int checks;
    int errors;
    int exp_temp;

    temp_sweep_gen #(
        .DWELL (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .lo_i        (lo_i),
        .hi_i        (hi_i),
        .step_i      (step_i),
        .ind_i       (ind_i),
        .temp_o      (temp_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .hits_o      (hits_o),
        .any_hit_o   (any_hit_o),
        .first_hit_o (first_hit_o),
        .last_hit_o  (last_hit_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Indicator trips on 160..175 and on even codes 176..190.
    function automatic bit ind_fn(input int t);
        return (t >= 160 && t <= 175) || (t >= 176 && t <= 190 && (t % 2) == 0);
    endfunction

    assign ind_i = ind_fn(int'(temp_o));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input int lo, input int hi, input int st, input bit hold);
        int sp, n, eh, ef, el, dc, cyc, done_cyc, seq_err, c;
        sp = (st == 0) ? 1 : st;
        n  = 0; eh = 0; ef = 0; el = 0;
        for (c = lo; c <= hi; c += sp) begin
            n++;
            if (ind_fn(c)) begin
                if (eh == 0) ef = c;
                el = c;
                eh++;
            end
        end
        dc = (n == 0) ? 1 : n * DW + 1;

        @(negedge clk_i);
        start_i = 1'b1;
        lo_i    = 8'(lo);
        hi_i    = 8'(hi);
        step_i  = 4'(st);
        @(posedge clk_i);
        #1;
        if (!hold) start_i = 1'b0;

        cyc      = 1;
        done_cyc = -1;
        seq_err  = 0;
        while (cyc <= BOUND && done_cyc < 0) begin
            if (done_o) begin
                done_cyc = cyc;
            end else if (cyc < dc) begin
                if (busy_o !== 1'b1 || int'(temp_o) != lo + ((cyc - 1) / DW) * sp)
                    seq_err++;
            end
            if (!hold && n > 0 && cyc == 3) begin
                start_i = 1'b1;
                lo_i    = 8'($urandom_range(0, 255));
                hi_i    = 8'($urandom_range(0, 255));
                step_i  = 4'($urandom_range(0, 15));
            end
            if (!hold && cyc == 4) start_i = 1'b0;
            if (done_cyc < 0) begin
                @(posedge clk_i);
                #1;
                cyc++;
            end
        end

        if (n > 0) exp_temp = lo + (n - 1) * sp;
        chk("done_cycle", done_cyc, dc);
        chk("sweep_seq_errs", seq_err, 0);
        chk("busy_at_done", int'(busy_o), 0);
        chk("hits", int'(hits_o), eh);
        chk("any_hit", int'(any_hit_o), (eh != 0) ? 1 : 0);
        chk("first_hit", int'(first_hit_o), ef);
        chk("last_hit", int'(last_hit_o), el);
        chk("temp_end", int'(temp_o), exp_temp);

        @(posedge clk_i);
        #1;
        chk("done_pulse_len", int'(done_o), 0);
        chk("busy_after_done", int'(busy_o), 0);
        chk("hits_held", int'(hits_o), eh);

        if (hold) begin
            @(posedge clk_i);
            #1;
            chk("rearm_busy", int'(busy_o), 1);
            chk("rearm_temp", int'(temp_o), lo);
            start_i = 1'b0;
            cyc = 0;
            while (!done_o && cyc < BOUND) begin
                @(posedge clk_i);
                #1;
                cyc++;
            end
            chk("rearm_done_seen", int'(done_o), 1);
            chk("rearm_hits", int'(hits_o), eh);
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        int lo, hi, st;
        checks   = 0;
        errors   = 0;
        exp_temp = 0;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        lo_i     = '0;
        hi_i     = '0;
        step_i   = '0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_temp", int'(temp_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_hits", int'(hits_o), 0);
        chk("rst_first", int'(first_hit_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_sweep(150, 200, 1, 1'b0);
        run_sweep(160, 190, 0, 1'b0);
        run_sweep(200, 100, 3, 1'b0);
        run_sweep(250, 255, 4, 1'b0);
        run_sweep(184, 184, 15, 1'b0);
        run_sweep(170, 180, 2, 1'b1);

        // Asynchronous reset in the middle of code 3.
        @(negedge clk_i);
        start_i = 1'b1;
        lo_i    = 8'd150;
        hi_i    = 8'd200;
        step_i  = 4'd1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (13) @(posedge clk_i);
        #1;
        chk("pre_rst_temp", int'(temp_o), 153);
        chk("pre_rst_hits", int'(hits_o), 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_temp", int'(temp_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_done", int'(done_o), 0);
        chk("arst_hits", int'(hits_o), 0);
        chk("arst_any", int'(any_hit_o), 0);
        chk("arst_first", int'(first_hit_o), 0);
        chk("arst_last", int'(last_hit_o), 0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        exp_temp = 0;
        run_sweep(150, 200, 1, 1'b0);

        for (int i = 0; i < 15; i++) begin
            lo = int'($urandom_range(120, 240));
            if ($urandom_range(0, 5) == 0) begin
                hi = int'($urandom_range(0, 119));
            end else begin
                hi = lo + int'($urandom_range(0, 50));
                if (hi > 255) hi = 255;
            end
            st = int'($urandom_range(0, 15));
            run_sweep(lo, hi, st, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_sweep_gen.md
# temp_sweep_gen

Stimulus-side companion to the temperature indicator: sweeps an 8-bit temperature code from a low to a high limit in programmable steps and drives it onto the indicator's `sw` input. It holds each code for a fixed dwell and samples the indicator's `led` response. It reports how many codes tripped the indicator, plus the first and last tripping codes. It sits between board controls (buttons/switches) and the indicator, for on-board self-check of the indicator's threshold bands.

## Interface
- `DWELL`, default 4: cycles each code is held; `ind` is sampled on the last of them; legal range 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level, sampled in IDLE only; begins a sweep.
- `lo`  in  8  first code; latched on start.
- `hi`  in  8  upper limit, inclusive; latched on start.
- `step`  in  4  code increment; latched on start; 0 treated as 1.
- `temp`  out  8  code driven to indicator `sw`.
- `ind`  in  1  indicator `led` response.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse at sweep end.
- `hits`  out  9  number of sampled codes with `ind`=1 (0..256).
- `any_hit`  out  1  `hits` != 0.
- `first_hit`  out  8  lowest code sampled with `ind`=1, else 0.
- `last_hit`  out  8  highest code sampled with `ind`=1, else 0.

## Operation
- States: IDLE, SWEEP, DONE.
- **IDLE**
  - On `start`=1, latch `lo`/`hi`/`step` and clear `hits`, `first_hit`, `last_hit`, `any_hit`.
  - If `lo`>`hi`, go to DONE with no codes sampled.
  - Otherwise set `temp`=`lo`, dwell counter=0, and go to SWEEP.
- **SWEEP**
  - The dwell counter increments each cycle.
  - At count DWELL-1, sample `ind`. If 1: `hits`+=1, `last_hit`=`temp`, `any_hit`=1, and `first_hit`=`temp` if this is the first hit.
  - Compute the next code as a 9-bit sum `temp`+`step`.
    - If the sum > `hi`, go to DONE and leave `temp` unchanged.
    - Otherwise load the new code into `temp` and reset the counter to 0.
  - Codes never wrap past 255.
- **DONE**: `done`=1 for one cycle, `busy`=0, then return to IDLE.
- `busy` = (state==SWEEP).
- `start` in SWEEP or DONE is ignored. A `start` held high re-arms in IDLE on the cycle after DONE.
- Results are held from DONE until the next accepted start.
- `lo`/`hi`/`step` changes during a sweep have no effect.
- Number of codes sampled: N = floor((hi-lo)/step')+1, where step' = max(step,1).
- Reset (any time, including mid-sweep): state IDLE, `temp`=0, `busy`=0, `done`=0, `hits`=0, `any_hit`=0, `first_hit`=0, `last_hit`=0, dwell counter=0.

## Timing
- Start accepted at edge E0.
  - `busy`=1 and `temp`=`lo` from cycle 1.
  - Code k (0-based) is driven in cycles 1+k·DWELL … (k+1)·DWELL.
  - `ind` is sampled in cycle (k+1)·DWELL.
- `done`=1 and `busy`=0 in cycle N·DWELL+1. Final results are already valid in that cycle.
- Earliest re-accepted `start`: cycle N·DWELL+2, when back in IDLE.
- For `lo`>`hi`: `done` in cycle 1, `busy` never asserted.
- Result registers update on the same edge as the sample.
- Indicator is combinational, so `ind` settles within the dwell for any DWELL≥1.

## Structure
- Package `temp_pkg`:
  - state enum (IDLE/SWEEP/DONE)
  - `TEMP_W`=8
  - `HITS_W`=9
  - `DWELL_DEF`=4
- Sub-module `dwell_timer`: parameterised DWELL counter with clear and a terminal-count output. It is instantiated once.
- The top holds the FSM, code register, limit latches and result registers.

## Test plan
Indicator model trips on codes 160–175 and even codes 176–190.
- `lo`=150, `hi`=200, `step`=1, DWELL=4 → `hits`=24, `first_hit`=160, `last_hit`=190, `any_hit`=1, `done` in cycle 205.
- `lo`=160, `hi`=190, `step`=0 → same as `step`=1 over 31 codes: `hits`=24, `done` in cycle 125.
- `lo`=200, `hi`=100 → `done` in cycle 1, `busy` never high, `hits`=0, `first_hit`=`last_hit`=0.
- `lo`=250, `hi`=255, `step`=4 → codes 250 and 254 only, no wrap to 2, `temp` ends at 254, `hits`=0.
- `lo`=`hi`=184, `step`=15 → one code, `hits`=1, `first_hit`=`last_hit`=184. A `start` pulse mid-sweep is ignored.
- `rst` asserted during code 3 of a sweep → all outputs 0 immediately (asynchronous). A new `start` after release runs a full, correct sweep.
